// File: rtl/gray_mem_responder_if.sv
// Bus bundle between the LBP initiator/host side and the gray image / result memory responder.
interface gray_mem_responder_if #(
  parameter int unsigned ADDR_W = 14
) ();
  logic              load_start;
  logic              img_wr;
  logic [ADDR_W-1:0] img_addr;
  logic [7:0]        img_data;
  logic              gray_req;
  logic [ADDR_W-1:0] gray_addr;
  logic              gray_ready;
  logic [7:0]        gray_data;
  logic              lbp_valid;
  logic [ADDR_W-1:0] lbp_addr;
  logic [7:0]        lbp_data;
  logic              finish;
  logic [ADDR_W-1:0] res_addr;
  logic [7:0]        res_data;
  logic [ADDR_W-1:0] wr_cnt;
  logic              err_border;
  logic              run_done;
  logic              run_ok;

  modport master (
    output load_start, img_wr, img_addr, img_data, gray_req, gray_addr,
           lbp_valid, lbp_addr, lbp_data, finish, res_addr,
    input  gray_ready, gray_data, res_data, wr_cnt, err_border, run_done, run_ok
  );

  modport slave (
    input  load_start, img_wr, img_addr, img_data, gray_req, gray_addr,
           lbp_valid, lbp_addr, lbp_data, finish, res_addr,
    output gray_ready, gray_data, res_data, wr_cnt, err_border, run_done, run_ok
  );
endinterface

// File: rtl/gray_mem_responder.sv
// Memory-side responder: holds the gray image, serves async reads, captures and
// checks LBP result writes for one run.
module gray_mem_responder #(
  parameter int unsigned IMG_W  = 128,
  parameter int unsigned ADDR_W = 14
) (
  input  logic               clk,
  input  logic               reset,
  gray_mem_responder_if.slave bus
);

  localparam int unsigned LOG_W   = $clog2(IMG_W);
  localparam int unsigned ROW_W   = ADDR_W - LOG_W;
  localparam int unsigned NPIX    = IMG_W * IMG_W;
  localparam int unsigned EXP_CNT = (IMG_W - 2) * (IMG_W - 2);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_LOADING = 2'd1,
    S_READY   = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            r_state;
  logic [ADDR_W:0]   r_load_cnt;
  logic [ADDR_W-1:0] r_wr_cnt;
  logic              r_err_border;
  logic              r_run_done;
  logic              r_run_ok;
  logic              r_gray_ready;

  logic [7:0] r_img [NPIX];
  logic [7:0] r_res [NPIX];

  logic              w_img_we;
  logic              w_lbp_we;
  logic [ROW_W-1:0]  w_row;
  logic [LOG_W-1:0]  w_col;
  logic              w_border;
  logic [ADDR_W:0]   w_load_nxt;
  logic              w_load_last;
  logic [ADDR_W-1:0] w_wr_inc;
  logic [ADDR_W-1:0] w_wr_acc;
  logic              w_err_acc;

  // load_start wins over any same-cycle write
  assign w_img_we    = (r_state == S_LOADING) & bus.img_wr & ~bus.load_start;
  assign w_lbp_we    = (r_state == S_READY) & bus.lbp_valid & ~bus.load_start;

  assign w_row       = bus.lbp_addr[ADDR_W-1:LOG_W];
  assign w_col       = bus.lbp_addr[LOG_W-1:0];
  assign w_border    = (w_row == '0) | (w_row == '1) | (w_col == '0) | (w_col == '1);

  assign w_load_nxt  = r_load_cnt + (ADDR_W+1)'(1);
  assign w_load_last = (w_load_nxt == (ADDR_W+1)'(NPIX));

  // counter and flag as they stand after this cycle's write, used for the run verdict
  assign w_wr_inc    = (r_wr_cnt == '1) ? r_wr_cnt : r_wr_cnt + ADDR_W'(1);
  assign w_wr_acc    = w_lbp_we ? w_wr_inc : r_wr_cnt;
  assign w_err_acc   = r_err_border | (w_lbp_we & w_border);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_EMPTY;
      r_load_cnt   <= '0;
      r_wr_cnt     <= '0;
      r_err_border <= 1'b0;
      r_run_done   <= 1'b0;
      r_run_ok     <= 1'b0;
      r_gray_ready <= 1'b0;
    end else if (bus.load_start) begin
      r_state      <= S_LOADING;
      r_load_cnt   <= '0;
      r_wr_cnt     <= '0;
      r_err_border <= 1'b0;
      r_run_done   <= 1'b0;
      r_run_ok     <= 1'b0;
      r_gray_ready <= 1'b0;
    end else begin
      case (r_state)
        S_LOADING: begin
          if (bus.img_wr) begin
            r_load_cnt <= w_load_nxt;
            if (w_load_last) begin
              r_state      <= S_READY;
              r_gray_ready <= 1'b1;
            end
          end
        end
        S_READY: begin
          r_wr_cnt     <= w_wr_acc;
          r_err_border <= w_err_acc;
          if (bus.finish) begin
            r_state    <= S_DONE;
            r_run_done <= 1'b1;
            r_run_ok   <= (w_wr_acc == ADDR_W'(EXP_CNT)) & ~w_err_acc;
          end
        end
        default: ;
      endcase
    end
  end

  // RAM arrays carry no reset; contents are undefined until reloaded
  always_ff @(posedge clk) begin
    if (w_img_we) r_img[bus.img_addr] <= bus.img_data;
    if (w_lbp_we) r_res[bus.lbp_addr] <= bus.lbp_data;
  end

  // gray reads stay combinational: the initiator samples on the very next edge
  assign bus.gray_data  = (bus.gray_req & r_gray_ready) ? r_img[bus.gray_addr] : 8'd0;
  assign bus.res_data   = r_res[bus.res_addr];
  assign bus.gray_ready = r_gray_ready;
  assign bus.wr_cnt     = r_wr_cnt;
  assign bus.err_border = r_err_border;
  assign bus.run_done   = r_run_done;
  assign bus.run_ok     = r_run_ok;

endmodule

// File: tb/tb_gray_mem_responder.sv
// Randomized self-checking bench for gray_mem_responder against a pixel-level reference model.
module tb_gray_mem_responder;

  localparam int IMG   = 128;
  localparam int NPIX  = IMG * IMG;
  localparam int EXPN  = (IMG - 2) * (IMG - 2);
  localparam int CMAX  = NPIX - 1;

  logic clk;
  logic reset;

  gray_mem_responder_if #(.ADDR_W(14)) bus ();

  gray_mem_responder #(.IMG_W(128), .ADDR_W(14)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model
  logic [7:0] img_m [NPIX];
  logic [7:0] res_m [NPIX];
  int  exp_wr;
  bit  exp_err, exp_done, exp_ready, in_run;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit is_border(input int a);
    int r, c;
    r = a / IMG;
    c = a % IMG;
    return (r == 0) || (r == IMG - 1) || (c == 0) || (c == IMG - 1);
  endfunction

  // 3x3 LBP code: bit k set when neighbour k (raster order, centre skipped) >= centre
  function automatic logic [7:0] lbp_of(input int a);
    int r, c, k;
    logic [7:0] v;
    r = a / IMG;
    c = a % IMG;
    v = 8'd0;
    k = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        if (dr != 0 || dc != 0) begin
          if (img_m[(r + dr) * IMG + c + dc] >= img_m[a]) v[k] = 1'b1;
          k++;
        end
      end
    end
    return v;
  endfunction

  function automatic int rand_interior();
    return int'($urandom_range(1, IMG - 2)) * IMG + int'($urandom_range(1, IMG - 2));
  endfunction

  task automatic check_flags(input string tag);
    check_val({tag, "_ready"},  32'(bus.gray_ready), 32'(exp_ready));
    check_val({tag, "_wrcnt"},  32'(bus.wr_cnt),     32'(exp_wr));
    check_val({tag, "_err"},    32'(bus.err_border), 32'(exp_err));
    check_val({tag, "_done"},   32'(bus.run_done),   32'(exp_done));
    check_val({tag, "_ok"},     32'(bus.run_ok),
              32'(exp_done && exp_wr == EXPN && !exp_err));
  endtask

  task automatic idle_bus();
    bus.load_start = 1'b0; bus.img_wr = 1'b0; bus.img_addr = '0; bus.img_data = '0;
    bus.gray_req = 1'b0; bus.gray_addr = '0; bus.lbp_valid = 1'b0; bus.lbp_addr = '0;
    bus.lbp_data = '0; bus.finish = 1'b0; bus.res_addr = '0;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    exp_wr = 0; exp_err = 0; exp_done = 0; exp_ready = 0; in_run = 0;
    #1;
    check_flags(tag);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // load_start pulse followed by n image writes (ramp or random data)
  task automatic load_image(input bit ramp, input int n);
    bus.load_start = 1'b1;
    #1 check_val("ready_before_ld", 32'(bus.gray_ready), 32'(exp_ready));
    @(negedge clk);
    bus.load_start = 1'b0;
    exp_wr = 0; exp_err = 0; exp_done = 0; exp_ready = 0; in_run = 0;
    check_flags("ld_clear");
    for (int a = 0; a < n; a++) begin
      bus.img_wr   = 1'b1;
      bus.img_addr = 14'(a);
      bus.img_data = ramp ? 8'(a) : 8'($urandom);
      img_m[a]     = bus.img_data;
      if (a % 4096 == 7) begin
        bus.gray_req  = 1'b1;
        bus.gray_addr = 14'($urandom);
        #1;
        check_val("gray_in_load", 32'(bus.gray_data), 32'd0);
        check_val("ready_in_load", 32'(bus.gray_ready), 32'd0);
        bus.gray_req = 1'b0;
      end
      if (a == NPIX - 1) #1 check_val("ready_last_wr", 32'(bus.gray_ready), 32'd0);
      @(negedge clk);
    end
    bus.img_wr = 1'b0;
    if (n == NPIX) begin
      exp_ready = 1;
      in_run    = 1;
      check_val("ready_after_ld", 32'(bus.gray_ready), 32'd1);
    end
  endtask

  task automatic lbp_write(input int a, input logic [7:0] d, input bit fin);
    bus.lbp_valid = 1'b1;
    bus.lbp_addr  = 14'(a);
    bus.lbp_data  = d;
    bus.finish    = fin;
    if (in_run) begin
      res_m[a] = d;
      if (exp_wr < CMAX) exp_wr++;
      if (is_border(a)) exp_err = 1;
      if (fin) begin exp_done = 1; in_run = 0; end
    end
    @(negedge clk);
    bus.lbp_valid = 1'b0;
    bus.finish    = 1'b0;
  endtask

  task automatic gray_probe(input string tag);
    int ga;
    bit rq;
    ga = int'($urandom_range(0, NPIX - 1));
    rq = 1'($urandom);
    bus.gray_req  = rq;
    bus.gray_addr = 14'(ga);
    #1 check_val(tag, 32'(bus.gray_data), (rq && exp_ready) ? 32'(img_m[ga]) : 32'd0);
  endtask

  task automatic res_probe(input string tag, input int a);
    bus.res_addr = 14'(a);
    #1 check_val(tag, 32'(bus.res_data), 32'(res_m[a]));
  endtask

  initial begin
    int a0;
    logic [7:0] old;
    idle_bus();
    reset = 1'b0;
    exp_wr = 0; exp_err = 0; exp_done = 0; exp_ready = 0; in_run = 0;
    repeat (3) @(negedge clk);
    bus.gray_req = 1'b1;
    #1;
    check_flags("rst");
    check_val("rst_gray", 32'(bus.gray_data), 32'd0);
    bus.gray_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // reset after a partial load
    load_image(1'b0, 5000);
    do_reset("rst_midload");
    bus.img_wr = 1'b1;
    @(negedge clk);
    bus.img_wr = 1'b0;
    check_val("ready_empty", 32'(bus.gray_ready), 32'd0);

    // ramp image and basic reads
    load_image(1'b1, NPIX);
    bus.gray_req  = 1'b1;
    bus.gray_addr = 14'd300;
    #1 check_val("gray_300", 32'(bus.gray_data), 32'd44);
    for (int i = 0; i < 40; i++) begin
      gray_probe("gray_rand");
      @(negedge clk);
    end
    bus.gray_req  = 1'b0;
    bus.gray_addr = 14'(NPIX - 1);
    #1 check_val("gray_noreq", 32'(bus.gray_data), 32'd0);

    // full LBP run, finish on the last write
    for (int r = 1; r < IMG - 1; r++) begin
      for (int c = 1; c < IMG - 1; c++) begin
        a0 = r * IMG + c;
        gray_probe("gray_run");
        lbp_write(a0, lbp_of(a0), (a0 == (IMG - 2) * IMG + IMG - 2));
      end
    end
    bus.gray_req = 1'b0;
    check_flags("run1");
    res_probe("res_129", 129);
    for (int i = 0; i < 20; i++) res_probe("res_rand", rand_interior());

    // writes and finish in DONE are ignored; reads still served
    old = res_m[129];
    lbp_write(129, ~old, 1'b1);
    check_flags("done_extra");
    res_probe("res_129_hold", 129);
    gray_probe("gray_done");
    bus.gray_req = 1'b0;

    // border hit makes the run fail
    load_image(1'b0, NPIX);
    for (int i = 0; i < 10; i++) lbp_write(rand_interior(), 8'($urandom), 1'b0);
    check_val("err_clean", 32'(bus.err_border), 32'd0);
    lbp_write(127, 8'($urandom), 1'b0);
    check_val("err_set", 32'(bus.err_border), 32'd1);
    for (int i = 0; i < 5; i++) begin
      lbp_write(rand_interior(), 8'($urandom), 1'b0);
      check_val("err_sticky", 32'(bus.err_border), 32'd1);
    end
    lbp_write(rand_interior(), 8'($urandom), 1'b1);
    check_flags("run2");
    res_probe("res_127", 127);
    do_reset("rst_done");

    // load_start mid-run clears everything; finish outside READY ignored
    load_image(1'b0, NPIX);
    for (int i = 0; i < 4; i++) lbp_write(i * IMG + 5, 8'($urandom), 1'b0);
    check_flags("run3_mid");
    load_image(1'b0, 100);
    bus.finish = 1'b1;
    @(negedge clk);
    bus.finish = 1'b0;
    check_flags("fin_loading");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
